// File: rtl/wallace_csa_pipe8_pkg.sv
// Shared constants and helpers for the 8x8 Wallace-tree carry-save front end.
package wallace_csa_pipe8_pkg;

  localparam int OP_W    = 8;
  localparam int OUT_W   = 2 * OP_W;
  localparam int TAG_W   = 4;
  localparam int LATENCY = 3;

  typedef logic [OUT_W-1:0] vec_t;

  // Partial-product row: multiplicand gated by one multiplier bit, placed at its weight.
  function automatic vec_t pp_row(input logic [OP_W-1:0] a, input logic b_bit, input int sh);
    vec_t r;
    r = vec_t'(a & {OP_W{b_bit}});
    return r << sh;
  endfunction

endpackage

// File: rtl/csa_row.sv
// 3:2 carry-save compressor over W bits; carry vector is pre-shifted to its weight.
module csa_row #(
  parameter int W = 16
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] z,
  output logic [W-1:0] s,
  output logic [W-1:0] c
);

  logic [W-2:0] maj;

  // The top majority bit would land past the result width, so it is never formed.
  assign maj = (x[W-2:0] & y[W-2:0]) | (x[W-2:0] & z[W-2:0]) | (y[W-2:0] & z[W-2:0]);
  assign s   = x ^ y ^ z;
  assign c   = {maj, 1'b0};

endmodule

// File: rtl/wallace_csa_pipe8.sv
// Three-stage pipelined 8x8 unsigned Wallace-tree reduction to sum/carry vectors
// feeding a 16-bit final adder; valid/ready on both sides with no bubbles.
module wallace_csa_pipe8
  import wallace_csa_pipe8_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_a,
  input  logic [OP_W-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] sum_vec,
  output logic [OUT_W-1:0] carry_vec,
  output logic [TAG_W-1:0] out_tag
);

  logic             v1, v2, v3;
  logic             adv1, adv2, adv3;
  logic [OP_W-1:0]  a1, b1;
  logic [TAG_W-1:0] t1, t2, t3;
  vec_t             r2 [4];
  vec_t             pp [OP_W];
  vec_t             l1_s0, l1_c0, l1_s1, l1_c1;
  vec_t             l2_s0, l2_c0, l2_s1, l2_c1;
  vec_t             l3_s, l3_c;
  vec_t             sum_nxt, carry_nxt;

  // A stage may take new data when it is empty or its contents move on this cycle.
  assign adv3     = !v3 || out_ready;
  assign adv2     = !v2 || adv3;
  assign adv1     = !v1 || adv2;
  assign in_ready = adv1;

  assign out_valid = v3;
  assign out_tag   = t3;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      a1 <= '0;
      b1 <= '0;
      t1 <= '0;
    end else if (adv1) begin
      v1 <= in_valid;
      if (in_valid) begin
        a1 <= in_a;
        b1 <= in_b;
        t1 <= in_tag;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < OP_W; i++) begin
      pp[i] = pp_row(a1, b1[i], i);
    end
  end

  // 8 -> 6
  csa_row #(.W(OUT_W)) u_l1a (.x(pp[0]), .y(pp[1]), .z(pp[2]), .s(l1_s0), .c(l1_c0));
  csa_row #(.W(OUT_W)) u_l1b (.x(pp[3]), .y(pp[4]), .z(pp[5]), .s(l1_s1), .c(l1_c1));

  // 6 -> 4
  csa_row #(.W(OUT_W)) u_l2a (.x(l1_s0), .y(l1_c0), .z(l1_s1), .s(l2_s0), .c(l2_c0));
  csa_row #(.W(OUT_W)) u_l2b (.x(l1_c1), .y(pp[6]), .z(pp[7]), .s(l2_s1), .c(l2_c1));

  always_ff @(posedge clk) begin
    if (rst) begin
      v2 <= 1'b0;
      t2 <= '0;
      for (int i = 0; i < 4; i++) r2[i] <= '0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        t2    <= t1;
        r2[0] <= l2_s0;
        r2[1] <= l2_c0;
        r2[2] <= l2_s1;
        r2[3] <= l2_c1;
      end
    end
  end

  // 4 -> 3 -> 2
  csa_row #(.W(OUT_W)) u_l3 (.x(r2[0]), .y(r2[1]), .z(r2[2]), .s(l3_s), .c(l3_c));
  csa_row #(.W(OUT_W)) u_l4 (.x(l3_s), .y(l3_c), .z(r2[3]), .s(sum_nxt), .c(carry_nxt));

  always_ff @(posedge clk) begin
    if (rst) begin
      v3        <= 1'b0;
      t3        <= '0;
      sum_vec   <= '0;
      carry_vec <= '0;
    end else if (adv3) begin
      v3 <= v2;
      if (v2) begin
        t3        <= t2;
        sum_vec   <= sum_nxt;
        carry_vec <= carry_nxt;
      end
    end
  end

endmodule

// File: tb/tb_wallace_csa_pipe8.sv
// Self-checking bench for wallace_csa_pipe8: directed scenarios plus a randomized
// stream scored against plain a*b arithmetic with tag and order tracking.
module tb_wallace_csa_pipe8;
  import wallace_csa_pipe8_pkg::*;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  in_a;
  logic [OP_W-1:0]  in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] sum_vec;
  logic [OUT_W-1:0] carry_vec;
  logic [TAG_W-1:0] out_tag;

  int checks = 0;
  int errors = 0;

  logic [OUT_W+TAG_W-1:0] expq [$];

  wallace_csa_pipe8 dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum_vec(sum_vec), .carry_vec(carry_vec), .out_tag(out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the downstream 16-bit final adder with carry-in 0.
  function automatic logic [15:0] cla16(input logic [15:0] op1, input logic [15:0] op2);
    logic [16:0] full;
    full = {1'b0, op1} + {1'b0, op2};
    return full[15:0];
  endfunction

  // Advance one clock; inputs are driven at +1 and outputs sampled at +2.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_tag = '0;
    repeat (2) next_cycle();
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (sum_vec !== 16'h0) begin errors++; $display("FAIL reset_sum_vec got %h want 0000", sum_vec); end
    checks++; if (carry_vec !== 16'h0) begin errors++; $display("FAIL reset_carry_vec got %h want 0000", carry_vec); end
    checks++; if (out_tag !== 4'h0) begin errors++; $display("FAIL reset_out_tag got %h want 0", out_tag); end
    next_cycle();
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_ff_ff();
    int lat;
    next_cycle();
    in_valid = 1'b1; in_a = 8'hFF; in_b = 8'hFF; in_tag = 4'd5; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ff_in_ready got %b want 1", in_ready); end
    next_cycle();
    in_valid = 1'b0;
    #1;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 10) begin
      next_cycle();
      #1;
      lat++;
    end
    checks++; if (lat != LATENCY) begin errors++; $display("FAIL ff_latency got %0d want %0d", lat, LATENCY); end
    checks++; if (cla16(sum_vec, carry_vec) !== 16'hFE01) begin errors++; $display("FAIL ff_product got %h want fe01", cla16(sum_vec, carry_vec)); end
    checks++; if (out_tag !== 4'd5) begin errors++; $display("FAIL ff_tag got %0d want 5", out_tag); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    logic [7:0]  av [3];
    logic [7:0]  bv [3];
    logic [15:0] ev [3];
    int idx;
    av[0] = 8'h00; bv[0] = 8'h37; ev[0] = 16'h0000;
    av[1] = 8'h01; bv[1] = 8'hAB; ev[1] = 16'h00AB;
    av[2] = 8'h80; bv[2] = 8'h02; ev[2] = 16'h0100;
    idx = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (cyc < 3) begin
        in_valid = 1'b1; in_a = av[cyc]; in_b = bv[cyc]; in_tag = 4'(cyc + 8);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid === 1'b1 && idx < 3) begin
        checks++; if (cyc != LATENCY + idx) begin errors++; $display("FAIL b2b_cycle[%0d] got %0d want %0d", idx, cyc, LATENCY + idx); end
        checks++; if (cla16(sum_vec, carry_vec) !== ev[idx]) begin errors++; $display("FAIL b2b_product[%0d] got %h want %h", idx, cla16(sum_vec, carry_vec), ev[idx]); end
        checks++; if (out_tag !== 4'(idx + 8)) begin errors++; $display("FAIL b2b_tag[%0d] got %0d want %0d", idx, out_tag, idx + 8); end
        idx++;
      end
      next_cycle();
    end
    checks++; if (idx != 3) begin errors++; $display("FAIL b2b_count got %0d want 3", idx); end
  endtask

  task automatic test_backpressure();
    int sent, got;
    logic [15:0] snap_s, snap_c;
    logic [3:0]  snap_t;
    logic [OUT_W+TAG_W-1:0] e;
    sent = 0; got = 0;
    snap_s = '0; snap_c = '0; snap_t = '0;
    expq.delete();
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 8'($urandom); in_b = 8'($urandom); in_tag = 4'd1;
    for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
      if (cyc == 6) out_ready = 1'b1;
      in_valid = (sent < 4);
      #1;
      if (cyc == 3) begin
        snap_s = sum_vec; snap_c = carry_vec; snap_t = out_tag;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid got %b want 1", out_valid); end
      end
      if (cyc == 5) begin
        checks++; if (sent != 3) begin errors++; $display("FAIL bp_accepted got %0d want 3", sent); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
        checks++; if ({sum_vec, carry_vec, out_tag} !== {snap_s, snap_c, snap_t}) begin
          errors++; $display("FAIL bp_stable got %h/%h/%h want %h/%h/%h", sum_vec, carry_vec, out_tag, snap_s, snap_c, snap_t);
        end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        e = (expq.size() > 0) ? expq.pop_front() : '1;
        checks++; if ({cla16(sum_vec, carry_vec), out_tag} !== e) begin
          errors++; $display("FAIL bp_result[%0d] got %h/%h want %h/%h", got, cla16(sum_vec, carry_vec), out_tag, e[19:4], e[3:0]);
        end
        got++;
      end
      if (in_valid === 1'b1 && in_ready === 1'b1) begin
        expq.push_back({16'(in_a * in_b), in_tag});
        sent++;
        next_cycle();
        in_a = 8'($urandom); in_b = 8'($urandom); in_tag = 4'(sent + 1);
      end else begin
        next_cycle();
      end
    end
    in_valid = 1'b0;
    checks++; if (got != 4) begin errors++; $display("FAIL bp_drained got %0d want 4", got); end
  endtask

  task automatic test_reset_mid();
    int stale;
    stale = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_a = 8'h11 + 8'(i); in_b = 8'h22; in_tag = 4'(i + 3);
      next_cycle();
    end
    in_valid = 1'b0;
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid got %b want 0", out_valid); end
    checks++; if ({sum_vec, carry_vec} !== 32'h0) begin errors++; $display("FAIL rstmid_vectors got %h/%h want 0/0", sum_vec, carry_vec); end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      #1;
      if (out_valid !== 1'b0) stale++;
    end
    checks++; if (stale != 0) begin errors++; $display("FAIL rstmid_stale got %0d want 0", stale); end
  endtask

  task automatic test_random();
    int sent, got, cyc, pv, pr;
    logic hold;
    logic [OUT_W+TAG_W-1:0] e;
    logic [15:0] res;
    sent = 0; got = 0; cyc = 0; hold = 1'b0;
    pv = 70; pr = 70;
    expq.delete();
    in_valid = 1'b0;
    while (got < 10000 && cyc < 80000) begin
      if (cyc % 500 == 0) begin
        pv = int'($urandom_range(20, 100));
        pr = int'($urandom_range(20, 100));
      end
      if (!hold) begin
        in_valid = (sent < 10000) && (int'($urandom_range(1, 100)) <= pv);
        in_a = 8'($urandom); in_b = 8'($urandom); in_tag = 4'($urandom);
      end
      out_ready = (int'($urandom_range(1, 100)) <= pr);
      #1;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        res = cla16(sum_vec, carry_vec);
        checks++;
        if (expq.size() == 0) begin
          errors++; $display("FAIL rand_unexpected got %h/%h want none", res, out_tag);
        end else begin
          e = expq.pop_front();
          if ({res, out_tag} !== e) begin
            errors++; $display("FAIL rand_result[%0d] got %h/%h want %h/%h", got, res, out_tag, e[19:4], e[3:0]);
          end
        end
        got++;
      end
      hold = (in_valid === 1'b1) && (in_ready !== 1'b1);
      if (in_valid === 1'b1 && in_ready === 1'b1) begin
        expq.push_back({16'(in_a * in_b), in_tag});
        sent++;
      end
      next_cycle();
      cyc++;
    end
    in_valid = 1'b0;
    checks++; if (got != 10000) begin errors++; $display("FAIL rand_count got %0d want 10000", got); end
  endtask

  initial begin
    test_reset();
    test_ff_ff();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
